// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared scheduler state encoding and crossbar control-word layout
package crossbar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    BUSY   = 2'd2
  } sched_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CB_N_INPUTS  = 2;
  localparam int CB_N_OUTPUTS = 2;
  localparam int CB_IN_W      = idx_width(CB_N_INPUTS);
  localparam int CB_OUT_W     = idx_width(CB_N_OUTPUTS);

  // Control word as seen by the crossbar: {in_sel, out_sel}
  typedef struct packed {
    logic [CB_IN_W-1:0]  in_sel;
    logic [CB_OUT_W-1:0] out_sel;
  } control_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set req bit at or after ptr, with wrap
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N = 2,
  localparam int PTR_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  int               idx;
  logic [PTR_W-1:0] sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crossbar_sched.sv
// rtl/crossbar_sched.sv - crossbar path scheduler; CROSSBAR_SCHED_TIMEOUT_EN adds the BUSY idle timeout
module crossbar_sched
  import crossbar_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int N_OUTPUTS = 2,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64,
  localparam int IN_W = idx_width(N_INPUTS),
  localparam int OUT_W = idx_width(N_OUTPUTS),
  localparam int CONTROL_BIT_WIDTH = IN_W + OUT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_INPUTS-1:0]          req,
  input  logic [N_INPUTS*OUT_W-1:0]    req_dest,
  input  logic [N_INPUTS-1:0]          xfer_fire,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  output logic [N_INPUTS-1:0]          grant,
  output logic                         busy
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  sched_state_t         state_q, state_d;
  logic [IN_W-1:0]      in_sel_q, rr_ptr, arb_idx, next_ptr;
  logic [OUT_W-1:0]     out_sel_q, arb_dest;
  logic [N_INPUTS-1:0]  arb_gnt;
  logic [7:0]           burst_cnt;
  logic                 fire_sel, burst_done, timeout_hit;

  rr_arbiter #(.N(N_INPUTS)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (arb_gnt[i]) arb_idx = IN_W'(i);
    end
    arb_dest = req_dest[int'(arb_idx)*OUT_W +: OUT_W];
    next_ptr = (int'(in_sel_q) == N_INPUTS - 1) ? '0 : in_sel_q + 1'b1;
  end

  // Only the owning input's handshakes count toward the burst
  assign fire_sel   = xfer_fire[in_sel_q];
  assign burst_done = (state_q == BUSY) && fire_sel && (burst_cnt == 8'(BURST_LEN - 1));

`ifdef CROSSBAR_SCHED_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout_hit = (state_q == BUSY) && !fire_sel && (idle_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (state_q == CONFIG && control_rdy) begin
        idle_cnt <= '0;
      end else if (state_q == BUSY) begin
        if (fire_sel || timeout_hit) idle_cnt <= '0;
        else                         idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = CONFIG;
      CONFIG:  if (control_rdy) state_d = BUSY;
      BUSY:    if (burst_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            in_sel_q  <= arb_idx;
            out_sel_q <= arb_dest;
          end
        end
        CONFIG: begin
          if (control_rdy) burst_cnt <= '0;
        end
        BUSY: begin
          if (burst_done || timeout_hit) begin
            burst_cnt <= '0;
            rr_ptr    <= next_ptr;
          end else if (fire_sel) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once
  always_comb begin
    control_val = (state_q == CONFIG);
    control     = (state_q == CONFIG) ? {in_sel_q, out_sel_q} : '0;
    busy        = (state_q != IDLE);
    grant       = '0;
    if (state_q == BUSY) grant[in_sel_q] = 1'b1;
  end

endmodule

// File: doc/crossbar_sched.md
CROSSBAR_SCHED -- requirements
Module: crossbar_sched

Interface
REQ-001 Parameter N_INPUTS, default 2: number of requesting crossbar input ports.
REQ-002 Parameter N_OUTPUTS, default 2: number of crossbar output ports.
REQ-003 Parameter BURST_LEN, default 4: message transfers per grant; legal range 1..255.
REQ-004 Parameter TIMEOUT, default 64: idle cycles in BUSY before abort; legal range 1..65535.
REQ-005 Derived constants: IN_W = max(1, clog2(N_INPUTS)), OUT_W = max(1, clog2(N_OUTPUTS)), CONTROL_BIT_WIDTH = IN_W + OUT_W.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 req  input  N_INPUTS  bit i set: input i requests a path.
REQ-009 req_dest  input  N_INPUTS*OUT_W  slice i: destination output index for input i.
REQ-010 xfer_fire  input  N_INPUTS  bit i set: crossbar input i completed a val/rdy handshake this cycle.
REQ-011 control  output  CONTROL_BIT_WIDTH  crossbar control word {in_sel, out_sel}.
REQ-012 control_val  output  1  control word valid.
REQ-013 control_rdy  input  1  crossbar accepts the control word.
REQ-014 grant  output  N_INPUTS  one-hot; marks the input that currently owns the path.
REQ-015 busy  output  1  high when not in IDLE.

Function
REQ-016 FSM states: IDLE, CONFIG, BUSY.
REQ-017 IDLE: if any req bit is set, select the first set bit at or after rr_ptr, scanning upward with wrap; latch in_sel and out_sel = req_dest[in_sel]; go to CONFIG next cycle.
REQ-018 IDLE with req == 0: stay in IDLE; all outputs remain at reset values.
REQ-019 CONFIG: control_val = 1 and control = latched {in_sel, out_sel}, both stable until control_rdy.
REQ-020 CONFIG with control_rdy = 1: the handshake fires; next state BUSY; burst counter cleared to 0.
REQ-021 BUSY: grant[in_sel] = 1; each cycle with xfer_fire[in_sel] = 1 increments the burst counter; xfer_fire on other bits is ignored.
REQ-022 BUSY exit: the cycle the counter reaches BURST_LEN, go to IDLE and set rr_ptr = (in_sel + 1) mod N_INPUTS.
REQ-023 Boundary: rr_ptr wraps from N_INPUTS-1 to 0; BURST_LEN = 1 exits after the first fire.
REQ-024 Boundary: req_dest values >= N_OUTPUTS pass to control unchanged; masking is the requester's responsibility.
REQ-025 Boundary: requester deassertion during CONFIG or BUSY does not abort; the grant holds until BURST_LEN fires.
REQ-026 Latency: IDLE with req to control_val is 1 cycle; control handshake to grant is 1 cycle.

Reset
REQ-027 On reset = 0, asynchronously: state IDLE, rr_ptr 0, counters 0, control 0, control_val 0, grant 0, busy 0, timeout 0.
REQ-028 Reset asserted mid-CONFIG or mid-BUSY drops all outputs immediately; no partial-burst memory remains after reset release.

Configuration
REQ-029 Macro CROSSBAR_SCHED_TIMEOUT_EN defined: adds output port timeout (1 bit) and an idle counter, cleared on every xfer_fire[in_sel].
REQ-030 With the macro, when the idle counter reaches TIMEOUT in BUSY: timeout pulses high for 1 cycle, the FSM goes to IDLE, and rr_ptr advances as in REQ-022.
REQ-031 Without the macro: no timeout port and no idle counter; BUSY waits indefinitely.

Structure
REQ-032 Package crossbar_pkg holds the state enum typedef (IDLE, CONFIG, BUSY) and the control-word field widths/typedef shared with the crossbar.
REQ-033 Sub-module rr_arbiter (N_INPUTS-wide, req and ptr in, one-hot grant out, purely combinational) performs the REQ-017 selection.

Verification
REQ-034 N_INPUTS=2, N_OUTPUTS=2, BURST_LEN=4: req=01, dest0=1, control_rdy=1 -> control={0,1} for 1 cycle; grant=01; after 4 fire[0], IDLE.
REQ-035 req=11 held over 3 grants -> grant order in0, in1, in0.
REQ-036 control_rdy held 0 for 5 cycles -> control_val and control stay stable; no grant until control_rdy=1.
REQ-037 reset=0 for 1 cycle mid-BUSY after 2 of 4 fires -> all outputs 0 in the same cycle; next req re-arbitrates from rr_ptr=0.
REQ-038 Macro defined, TIMEOUT=8, no fire in BUSY -> timeout pulses 1 cycle at the 8th idle cycle; state IDLE; rr_ptr advanced.
REQ-039 fire[1] pulses while in0 is granted -> burst counter unchanged.
